// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Index of the set bit in a one-hot vector of up to eight ports.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_grant.sv
// Grant selection for the memory port arbiter.
// Default: round-robin search starting after the last granted port.
// MEM_ARB_FIXED_PRIO_EN: fixed priority, lowest port index wins, pointer ignored.
module rr_grant #(
  parameter int NPORTS = 2,
  parameter int IW     = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic [NPORTS-1:0] req_i,
  input  logic [IW-1:0]     ptr_i,
  input  logic              en_i,
  output logic [NPORTS-1:0] grant_o
);

  logic          found;
  logic [IW-1:0] idx;

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Lowest requesting index wins.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < NPORTS; i++) begin
      idx = IW'(i);
      if (en_i && !found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end
`else
  // Search ptr+1 .. ptr+NPORTS modulo NPORTS; first requester wins.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 1; i <= NPORTS; i++) begin
      idx = IW'((int'(ptr_i) + i) % NPORTS);
      if (en_i && !found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// N-port front end sharing one single-port memory, one transaction in flight.
// Arbitration is round-robin unless MEM_ARB_FIXED_PRIO_EN is defined, in which
// case the lowest port index always wins (timing identical in both modes).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NPORTS      = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic [NPORTS-1:0]    req_valid,
  output logic [NPORTS-1:0]    req_ready,
  input  logic [NPORTS-1:0]    req_we,
  input  logic [NPORTS*2-1:0]  req_size,
  input  logic [NPORTS*AW-1:0] req_addr,
  input  logic [NPORTS*DW-1:0] req_wdata,
  output logic [NPORTS-1:0]    rsp_valid,
  output logic [DW-1:0]        rsp_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [1:0]           mem_size,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata
);

  localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  state_t        state_q, state_d;
  logic [IW-1:0] g_q, g_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [1:0]    mem_size_q, mem_size_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic [NPORTS-1:0] grant;
  logic [IW-1:0]     g_idx;

  rr_grant #(
    .NPORTS (NPORTS),
    .IW     (IW)
  ) u_grant (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .en_i    (state_q == IDLE),
    .grant_o (grant)
  );

  assign g_idx = IW'(onehot_to_idx(8'(grant)));

  // Next-state, command latch, latency counter and read capture.
  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_wdata_d = '0;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          g_d         = g_idx;
          ptr_d       = g_idx;
          rdata_d     = '0;
          mem_en_d    = 1'b1;
          mem_we_d    = req_we[g_idx];
          mem_size_d  = req_size[int'(g_idx)*2 +: 2];
          mem_addr_d  = req_addr[int'(g_idx)*AW +: AW];
          mem_wdata_d = req_wdata[int'(g_idx)*DW +: DW];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_we_q) begin
          state_d = RESP;
        end else begin
          cnt_d   = 3'(MEM_LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A zero count is treated like one so the FSM can never stall here.
        if (cnt_q <= 3'd1) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered memory command; reset drops any pending response.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q     <= IDLE;
      g_q         <= '0;
      ptr_q       <= IW'(NPORTS - 1);
      cnt_q       <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_size_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Ready is held low while reset is asserted so every output reads 0.
  assign req_ready = grant & {NPORTS{areset}};
  assign rsp_valid = (state_q == RESP) ? (NPORTS'(1) << g_q) : '0;
  assign rsp_rdata = (state_q == RESP) ? rdata_q : '0;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_size  = mem_size_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances cover NPORTS=3/L=2,
// NPORTS=1/L=1 and NPORTS=2/L=7. Expected grant order follows
// MEM_ARB_FIXED_PRIO_EN when that macro is defined.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: 3 ports, latency 2
  logic [2:0]  a_req_valid, a_req_ready, a_req_we, a_rsp_valid;
  logic [5:0]  a_req_size;
  logic [95:0] a_req_addr, a_req_wdata;
  logic [31:0] a_rsp_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_mem_en, a_mem_we;
  logic [1:0]  a_mem_size;
  // Instance B: 1 port, latency 1
  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid;
  logic [1:0]  b_req_size;
  logic [31:0] b_req_addr, b_req_wdata;
  logic [31:0] b_rsp_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_mem_en, b_mem_we;
  logic [1:0]  b_mem_size;
  // Instance C: 2 ports, latency 7
  logic [1:0]  c_req_valid, c_req_ready, c_req_we, c_rsp_valid;
  logic [3:0]  c_req_size;
  logic [63:0] c_req_addr, c_req_wdata;
  logic [31:0] c_rsp_rdata, c_mem_addr, c_mem_wdata, c_mem_rdata;
  logic        c_mem_en, c_mem_we;
  logic [1:0]  c_mem_size;

  mem_port_arbiter #(.NPORTS(3), .AW(32), .DW(32), .MEM_LATENCY(2)) dut_a (
    .clk(clk), .areset(areset), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(a_req_we), .req_size(a_req_size), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_size(a_mem_size),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata));

  mem_port_arbiter #(.NPORTS(1), .AW(32), .DW(32), .MEM_LATENCY(1)) dut_b (
    .clk(clk), .areset(areset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_size(b_req_size), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_size(b_mem_size),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata));

  mem_port_arbiter #(.NPORTS(2), .AW(32), .DW(32), .MEM_LATENCY(7)) dut_c (
    .clk(clk), .areset(areset), .req_valid(c_req_valid), .req_ready(c_req_ready),
    .req_we(c_req_we), .req_size(c_req_size), .req_addr(c_req_addr),
    .req_wdata(c_req_wdata), .rsp_valid(c_rsp_valid), .rsp_rdata(c_rsp_rdata),
    .mem_en(c_mem_en), .mem_we(c_mem_we), .mem_size(c_mem_size),
    .mem_addr(c_mem_addr), .mem_wdata(c_mem_wdata), .mem_rdata(c_mem_rdata));

  // Memory contents model; 0x100 holds 0xDEADBEEF.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A5A5A);
  endfunction

  // Memory models: data valid only in the L-th cycle after mem_en, junk otherwise.
  logic [7:0]  a_pv = '0, b_pv = '0, c_pv = '0;
  logic [31:0] a_pa [8];
  logic [31:0] b_pa [8];
  logic [31:0] c_pa [8];
  always @(posedge clk) begin
    a_pv <= {a_pv[6:0], a_mem_en};
    b_pv <= {b_pv[6:0], b_mem_en};
    c_pv <= {c_pv[6:0], c_mem_en};
    a_pa[0] <= a_mem_addr;
    b_pa[0] <= b_mem_addr;
    c_pa[0] <= c_mem_addr;
    for (int k = 1; k < 8; k++) begin
      a_pa[k] <= a_pa[k-1];
      b_pa[k] <= b_pa[k-1];
      c_pa[k] <= c_pa[k-1];
    end
  end
  assign a_mem_rdata = a_pv[1] ? mem_fn(a_pa[1]) : 32'hBADBAD00;
  assign b_mem_rdata = b_pv[0] ? mem_fn(b_pa[0]) : 32'hBADBAD00;
  assign c_mem_rdata = c_pv[6] ? mem_fn(c_pa[6]) : 32'hBADBAD00;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  logic [2:0] exp_order [6];
  int got;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    areset = 1'b0;
    a_req_valid = '0; a_req_we = '0; a_req_size = '0; a_req_addr = '0; a_req_wdata = '0;
    b_req_valid = '0; b_req_we = '0; b_req_size = '0; b_req_addr = '0; b_req_wdata = '0;
    c_req_valid = '0; c_req_we = '0; c_req_size = '0; c_req_addr = '0; c_req_wdata = '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 6; i++) exp_order[i] = 3'b001;
`else
    for (int i = 0; i < 6; i++) exp_order[i] = 3'b001 << (i % 3);
`endif

    // Reset state
    smp();
    chk("reset_outs_a", {a_req_ready, a_rsp_valid, a_rsp_rdata, a_mem_en, a_mem_we,
                         a_mem_size, a_mem_addr, a_mem_wdata}, '0);
    chk("reset_outs_bc", {b_req_ready, b_rsp_valid, b_mem_en, c_req_ready, c_rsp_valid, c_mem_en}, '0);
    edge_();
    areset = 1'b1;

    // Single read, port 0, latency 2
    a_req_valid = 3'b001; a_req_we = 3'b000;
    a_req_size[1:0] = SIZE_WORD; a_req_addr[31:0] = 32'h100;
    smp();
    chk("rd_ready_c0", a_req_ready, 3'b001);
    chk("rd_mem_en_c0", a_mem_en, 1'b0);
    edge_();
    a_req_valid = 3'b000;
    smp();
    chk("rd_mem_c1", {a_mem_en, a_mem_we, a_mem_size, a_mem_addr}, {1'b1, 1'b0, 2'b10, 32'h100});
    for (int c = 2; c <= 3; c++) begin
      edge_(); smp();
      chk("rd_rsp_early", {a_rsp_valid, a_mem_en}, '0);
    end
    edge_(); smp();
    chk("rd_rsp_c4", {a_rsp_valid, a_rsp_rdata}, {3'b001, 32'hDEADBEEF});
    edge_(); smp();
    chk("rd_rsp_c5", a_rsp_valid, 3'b000);

    // Write, port 1
    edge_();
    a_req_valid = 3'b010; a_req_we = 3'b010;
    a_req_size[3:2] = SIZE_WORD; a_req_addr[63:32] = 32'h200; a_req_wdata[63:32] = 32'h12345678;
    smp();
    chk("wr_ready_c0", a_req_ready, 3'b010);
    edge_();
    a_req_valid = 3'b000; a_req_we = 3'b000;
    smp();
    chk("wr_mem_c1", {a_mem_en, a_mem_we, a_mem_size, a_mem_addr, a_mem_wdata},
        {1'b1, 1'b1, 2'b10, 32'h200, 32'h12345678});
    edge_(); smp();
    chk("wr_rsp_c2", {a_rsp_valid, a_rsp_rdata, a_mem_en}, {3'b010, 32'h0, 1'b0});
    edge_(); smp();
    chk("wr_after_c3", {a_rsp_valid, a_mem_en, a_mem_we, a_mem_wdata}, '0);

    // Contention from fresh reset, all three ports continuously valid
    edge_();
    areset = 1'b0;
    smp();
    edge_();
    areset = 1'b1;
    a_req_valid = 3'b111; a_req_we = 3'b000;
    a_req_addr = {32'h320, 32'h310, 32'h300};
    got = 0;
    for (int c = 0; c < 200 && got < 6; c++) begin
      smp();
      if (a_req_ready != 3'b000) begin
        chk("contention_grant", a_req_ready, exp_order[got]);
        got++;
      end
      edge_();
    end
    a_req_valid = 3'b000;
    chk("contention_count", got, 6);
    repeat (6) edge_();

    // Reset during WAIT of a port 0 read
    a_req_valid = 3'b001; a_req_addr[31:0] = 32'h100;
    smp();
    chk("rstw_ready_c0", a_req_ready, 3'b001);
    edge_();
    a_req_valid = 3'b000;
    edge_();
    areset = 1'b0;
    #1;
    chk("rstw_outs", {a_req_ready, a_rsp_valid, a_rsp_rdata, a_mem_en, a_mem_we,
                      a_mem_size, a_mem_addr, a_mem_wdata}, '0);
    edge_(); smp();
    edge_();
    areset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      smp();
      chk("rstw_no_rsp", {a_rsp_valid, a_rsp_rdata}, '0);
      edge_();
    end
    a_req_valid = 3'b011; a_req_addr[63:32] = 32'h310;
    smp();
    chk("rstw_port0_first", a_req_ready, 3'b001);
    edge_();
    a_req_valid = 3'b010;
    for (int c = 1; c <= 4; c++) begin
      smp();
      chk("rstw_p1_wait", a_req_ready, 3'b000);
      edge_();
    end
    smp();
    chk("rstw_p1_grant", a_req_ready, 3'b010);
    edge_();
    a_req_valid = 3'b000;
    repeat (6) edge_();

    // Idle for 20 cycles
    for (int c = 0; c < 20; c++) begin
      smp();
      chk("idle", {a_mem_en, a_req_ready, a_rsp_valid}, '0);
      edge_();
    end

    // Latency 1, single port
    b_req_valid = 1'b1; b_req_addr = 32'h40; b_req_size = SIZE_BYTE;
    smp();
    chk("l1_ready_c0", b_req_ready, 1'b1);
    edge_();
    b_req_valid = 1'b0;
    smp();
    chk("l1_mem_c1", {b_mem_en, b_mem_size, b_mem_addr}, {1'b1, 2'b00, 32'h40});
    edge_(); smp();
    chk("l1_rsp_c2", b_rsp_valid, 1'b0);
    edge_(); smp();
    chk("l1_rsp_c3", {b_rsp_valid, b_rsp_rdata}, {1'b1, 32'h5A5A5A1A});
    edge_(); smp();
    chk("l1_rsp_c4", b_rsp_valid, 1'b0);

    // Latency 7, port 1 of two
    edge_();
    c_req_valid = 2'b10; c_req_addr[63:32] = 32'h300; c_req_size[3:2] = SIZE_HALF;
    smp();
    chk("l7_ready_c0", c_req_ready, 2'b10);
    edge_();
    c_req_valid = 2'b00;
    smp();
    chk("l7_mem_c1", {c_mem_en, c_mem_size, c_mem_addr}, {1'b1, 2'b01, 32'h300});
    for (int c = 2; c <= 8; c++) begin
      edge_(); smp();
      chk("l7_rsp_early", c_rsp_valid, 2'b00);
    end
    edge_(); smp();
    chk("l7_rsp_c9", {c_rsp_valid, c_rsp_rdata}, {2'b10, 32'h5A5A595A});
    edge_(); smp();
    chk("l7_rsp_c10", c_rsp_valid, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised N-port front end that shares one single-port main memory between the instruction-fetch, data and future ports (DMA, debug).
- Replaces the fixed two-port instruction/data merge.
- One transaction in flight; configurable memory read latency; round-robin arbitration; valid/ready requests with response pulses.
- Sits between the riscv core ports and main memory in the top level.

Parameters:
- NPORTS, 2, number of requester ports (2..8).
- AW, 32, address width.
- DW, 32, data width.
- MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata (1..7).

Ports:
- clk  in  1  clock, all logic on rising edge.
- areset  in  1  asynchronous, active-low reset.
- req_valid  in  NPORTS  per-port request valid.
- req_ready  out  NPORTS  per-port request accepted; one-hot or zero.
- req_we  in  NPORTS  1=write, 0=read.
- req_size  in  NPORTS*2  access size: 00 byte, 01 half, 10 word.
- req_addr  in  NPORTS*AW  byte address.
- req_wdata  in  NPORTS*DW  write data.
- rsp_valid  out  NPORTS  one-cycle completion pulse, per port.
- rsp_rdata  out  DW  read data; valid when any rsp_valid is high.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_size  out  2  memory access size.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid MEM_LATENCY cycles after mem_en.

Behaviour:
- Reset (areset low, asynchronous): state=IDLE; rr pointer=NPORTS-1, so port 0 wins first; all outputs 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, req_ready[g]=1 combinationally for the winner g.
  - On accept, latch g, we, size, addr, wdata; pointer<=g; go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE: mem_en=1 for exactly one cycle with latched command on registered mem_* outputs. Write -> RESP. Read -> WAIT.
- WAIT:
  - Counter loaded with MEM_LATENCY, decremented each cycle.
  - mem_rdata captured in the cycle the counter reaches 1, i.e. the MEM_LATENCY-th cycle after the ISSUE cycle.
  - Then go to RESP.
- RESP: rsp_valid[g]=1 for one cycle; rsp_rdata=captured data, 0 for writes; then IDLE.
- Timing, accept in cycle 0:
  - mem_en in cycle 1.
  - Read rsp_valid in cycle 2+MEM_LATENCY.
  - Write rsp_valid in cycle 2.
  - Next accept no earlier than the cycle after RESP.
- Round-robin: search ports pointer+1 .. pointer+NPORTS modulo NPORTS; first with req_valid wins. The pointer updates only on accept.
- Requester rules:
  - Requesters hold valid and command stable until ready.
  - Deasserting valid before ready is illegal. Behaviour is undefined, but the FSM must never hang.
- mem_* outputs hold 0 outside ISSUE, except mem_addr and mem_size, which may hold their last value.
- Port count and latency extremes:
  - NPORTS=1 degenerates to a pass-through with the same timing.
  - MEM_LATENCY=1 means WAIT lasts exactly one cycle.
- Reset mid-transaction: pending response is dropped; no rsp_valid; late mem_rdata ignored.
- All ports requesting continuously: each port is granted once per NPORTS accepts. No starvation.

Optional Feature:
- Macro MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest port index wins; rr pointer logic is removed.
- Undefined (default): round-robin as above.
- All timing is identical in both modes.

Decomposition:
- Package mem_arb_pkg:
  - state_t enum {IDLE, ISSUE, WAIT, RESP}.
  - Size constants SIZE_BYTE, SIZE_HALF, SIZE_WORD.
  - Function onehot_to_idx.
- Sub-module rr_grant:
  - Inputs: NPORTS request vector, pointer, enable.
  - Output: one-hot grant.
  - Contains the MEM_ARB_FIXED_PRIO_EN switch.
- FSM, latency counter and command latch stay in mem_port_arbiter.

Test Plan:
- Single read, MEM_LATENCY=2: port 0 read addr 0x100 with memory returning 0xDEADBEEF -> req_ready[0] in cycle 0, mem_en cycle 1, rsp_valid[0] in cycle 4 with rdata 0xDEADBEEF.
- Write: port 1 write 0x200 data 0x12345678 size 10 -> mem_en/mem_we cycle 1 with that addr/data/size; rsp_valid[1] cycle 2 with rdata 0.
- Contention, NPORTS=3, all valid continuously -> grant order 0,1,2,0,1,2. With MEM_ARB_FIXED_PRIO_EN, port 0 is granted every time.
- Latency sweep MEM_LATENCY=1 and 7: read response in cycle 3 and cycle 9 respectively; mem_rdata outside the capture cycle ignored.
- Reset during WAIT: areset low in cycle 2 of a read -> all outputs 0 immediately; no rsp_valid after release; next request to port 0 is granted first.
- Idle: no req_valid for 20 cycles -> mem_en, req_ready and rsp_valid stay 0.
